// File: rtl/prefix_scan_pipe_pkg.sv
// Shared definitions for the prefix-scan pipeline.
//   - SCAN_INCL / SCAN_EXCL : encoding of the per-vector scan mode bit.
//   - psum_clog2            : constant ceil(log2(n)), used to size the stage chain.
//   - `PSUM_LANE(v,i,w)     : selects lane i (width w) of a lane-packed vector,
//                             lane 0 in the least significant bits.
// Optional feature macro used by the files importing this package: PSUM_OVF_FLAG_EN.

`ifndef PSUM_LANE
`define PSUM_LANE(v, i, w) v[(w)*((i)+1)-1 -: (w)]
`endif

package prefix_scan_pipe_pkg;

  localparam logic SCAN_INCL = 1'b0;
  localparam logic SCAN_EXCL = 1'b1;

  function automatic int psum_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_scan_pipe_ks_stage.sv
// psum_ks_stage: one registered Kogge-Stone step of the prefix scan.
// Lane i (i >= SHIFT) becomes prev[i] + prev[i-SHIFT]; lower lanes pass through.
// Valid, tag and the clear/excl control bits travel with the data.
// Optional feature macro: PSUM_OVF_FLAG_EN (adds a per-vector overflow flag).
// Ports:
//   clk, reset          clock, asynchronous active-high reset (valid only)
//   en                  stage advance enable (hold when 0)
//   prev_vld/tag/clear/excl/data   values from the previous stage
//   stage_vld/tag/clear/excl/data  registered values of this stage
//   prev_ovf/stage_ovf  overflow flag in/out (PSUM_OVF_FLAG_EN only)

module psum_ks_stage
  import prefix_scan_pipe_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 3,
  parameter int SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  prev_vld,
  input  logic [TAGW-1:0]       prev_tag,
  input  logic                  prev_clear,
  input  logic                  prev_excl,
  input  logic [LANES*DW-1:0]   prev_data,
  output logic                  stage_vld,
  output logic [TAGW-1:0]       stage_tag,
  output logic                  stage_clear,
  output logic                  stage_excl,
  output logic [LANES*DW-1:0]   stage_data
`ifdef PSUM_OVF_FLAG_EN
  ,
  input  logic                  prev_ovf,
  output logic                  stage_ovf
`endif
);

  logic [LANES*DW-1:0] sum;
`ifdef PSUM_OVF_FLAG_EN
  logic [LANES-1:0]    cy;
`endif

  always_comb begin
    sum = prev_data;
`ifdef PSUM_OVF_FLAG_EN
    cy  = '0;
`endif
    for (int i = SHIFT; i < LANES; i++) begin
`ifdef PSUM_OVF_FLAG_EN
      {cy[i], `PSUM_LANE(sum, i, DW)} = {1'b0, `PSUM_LANE(prev_data, i, DW)}
                                      + {1'b0, `PSUM_LANE(prev_data, i - SHIFT, DW)};
`else
      `PSUM_LANE(sum, i, DW) = `PSUM_LANE(prev_data, i, DW)
                             + `PSUM_LANE(prev_data, i - SHIFT, DW);
`endif
    end
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_vld <= 1'b0;
    end else if (en) begin
      stage_vld <= prev_vld;
    end
  end

  // Payload is qualified by stage_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      stage_tag   <= prev_tag;
      stage_clear <= prev_clear;
      stage_excl  <= prev_excl;
      stage_data  <= sum;
`ifdef PSUM_OVF_FLAG_EN
      stage_ovf   <= prev_ovf | (|cy);
`endif
    end
  end

endmodule

// File: rtl/prefix_scan_pipe.sv
// prefix_scan_pipe: pipelined, parameterised prefix-sum (scan) unit.
// log2(LANES) Kogge-Stone stages produce per-vector inclusive partial sums;
// a final carry stage adds the running carry, applies inclusive/exclusive
// mode and registers the result. One vector per cycle, latency log2(LANES)+1.
// A single global enable stalls the whole pipe when the output is held.
// Optional feature macro: PSUM_OVF_FLAG_EN (sticky overflow flag, out_ovf).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_v / in_ready            input handshake
//   in_clear, in_excl, in_tag  per-vector control: new sequence, exclusive mode, tag
//   in_data                    LANES x DW input, lane i at [DW*(i+1)-1 -: DW]
//   out_v / out_ready          output handshake
//   out_tag, out_data          tag and scan result of the presented vector
//   out_total                  carry after this vector (carry-in + sum of lanes)
//   out_ovf                    sticky overflow flag (PSUM_OVF_FLAG_EN only)

module prefix_scan_pipe
  import prefix_scan_pipe_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_v,
  output logic                  in_ready,
  input  logic                  in_clear,
  input  logic                  in_excl,
  input  logic [TAGW-1:0]       in_tag,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_v,
  input  logic                  out_ready,
  output logic [TAGW-1:0]       out_tag,
  output logic [LANES*DW-1:0]   out_data,
  output logic [DW-1:0]         out_total
`ifdef PSUM_OVF_FLAG_EN
  ,
  output logic                  out_ovf
`endif
);

  localparam int L = psum_clog2(LANES);

  logic                          en;
  logic [L:0]                    vld_p;
  logic [L:0]                    clear_p;
  logic [L:0]                    excl_p;
  logic [L:0][TAGW-1:0]          tag_p;
  logic [L:0][LANES*DW-1:0]      data_p;
`ifdef PSUM_OVF_FLAG_EN
  logic [L:0]                    ovf_p;
`endif

  // The only stall source is a held output; bubbles still advance when en=1.
  assign en       = !(out_v && !out_ready);
  assign in_ready = en;

  // ---- p0: unregistered input ----
  assign vld_p[0]   = in_v;
  assign clear_p[0] = in_clear;
  assign excl_p[0]  = in_excl;
  assign tag_p[0]   = in_tag;
  assign data_p[0]  = in_data;
`ifdef PSUM_OVF_FLAG_EN
  assign ovf_p[0]   = 1'b0;
`endif

  // ---- p1..pL: Kogge-Stone stages, stage k adds lane i-2^k ----
  for (genvar k = 0; k < L; k++) begin : g_ks
    psum_ks_stage #(
      .LANES (LANES),
      .DW    (DW),
      .TAGW  (TAGW),
      .SHIFT (1 << k)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .prev_vld    (vld_p[k]),
      .prev_tag    (tag_p[k]),
      .prev_clear  (clear_p[k]),
      .prev_excl   (excl_p[k]),
      .prev_data   (data_p[k]),
      .stage_vld   (vld_p[k+1]),
      .stage_tag   (tag_p[k+1]),
      .stage_clear (clear_p[k+1]),
      .stage_excl  (excl_p[k+1]),
      .stage_data  (data_p[k+1])
`ifdef PSUM_OVF_FLAG_EN
      ,
      .prev_ovf    (ovf_p[k]),
      .stage_ovf   (ovf_p[k+1])
`endif
    );
  end

  // ---- carry stage: running carry, mode select, output register ----
  logic [DW-1:0]       carry_reg;
  logic [DW-1:0]       carry_in;
  logic [DW-1:0]       total;
  logic [LANES*DW-1:0] incl_sum;
  logic [LANES*DW-1:0] result;
`ifdef PSUM_OVF_FLAG_EN
  logic [LANES-1:0]    cy;
  logic                ovf_reg;
  logic                ovf_next;
`endif

  always_comb begin
    // The clear bit travels with its vector, so it only affects that vector.
    carry_in = clear_p[L] ? '0 : carry_reg;
    incl_sum = '0;
`ifdef PSUM_OVF_FLAG_EN
    cy       = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
`ifdef PSUM_OVF_FLAG_EN
      {cy[i], `PSUM_LANE(incl_sum, i, DW)} = {1'b0, carry_in} + {1'b0, `PSUM_LANE(data_p[L], i, DW)};
`else
      `PSUM_LANE(incl_sum, i, DW) = carry_in + `PSUM_LANE(data_p[L], i, DW);
`endif
    end
    // Exclusive result is the inclusive one shifted up a lane with carry_in in lane 0.
    if (excl_p[L] == SCAN_INCL) begin
      result = incl_sum;
    end else begin
      result = {incl_sum[(LANES-1)*DW-1:0], carry_in};
    end
    // The top-lane adder doubles as the total adder (c + s[LANES-1]).
    total = `PSUM_LANE(incl_sum, LANES-1, DW);
`ifdef PSUM_OVF_FLAG_EN
    ovf_next = ovf_p[L] | (|cy) | (clear_p[L] ? 1'b0 : ovf_reg);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v     <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      out_total <= '0;
      carry_reg <= '0;
`ifdef PSUM_OVF_FLAG_EN
      out_ovf   <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else if (en) begin
      out_v <= vld_p[L];
      // Bubbles leave the carry and the last presented result untouched.
      if (vld_p[L]) begin
        out_tag   <= tag_p[L];
        out_data  <= result;
        out_total <= total;
        carry_reg <= total;
`ifdef PSUM_OVF_FLAG_EN
        out_ovf   <= ovf_next;
        ovf_reg   <= ovf_next;
`endif
      end
    end
  end

endmodule
